// File: rtl/ula_pkg.sv
// Shared constants, opcode encodings and controller state type for the ULA
// register-file controller.
package ula_pkg;
    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 2;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        RESP
    } state_e;
endpackage

// File: rtl/ula_regfile_ctrl_if.sv
// Instruction request / result response handshake bundle between an issuer
// (master) and the ULA register-file controller (slave).
interface ula_regfile_ctrl_if;
    import ula_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_op;
    logic [REG_ADDR_W-1:0] in_rs1;
    logic [REG_ADDR_W-1:0] in_rs2;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;
    logic                  out_ready;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ula_regfile.sv
// 4 x DATA_W register file: two asynchronous read ports, one synchronous
// write port. Write source selection lives in the controller.
module ula_regfile
    import ula_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0]     rdata_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]     rdata_b
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/ula_regfile_ctrl.sv
// Non-pipelined controller sequencing register reads, an external ALU and
// write-back. Optional zero flag output enabled by ULA_ZERO_FLAG_EN.
module ula_regfile_ctrl
    import ula_pkg::*;
#(
    parameter int DATA_W = ula_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_en,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    ula_regfile_ctrl_if.slave     bus,
    output logic [DATA_W-1:0]     ula_a,
    output logic [DATA_W-1:0]     ula_b,
    output logic                  ula_f1,
    output logic                  ula_f2,
`ifdef ULA_ZERO_FLAG_EN
    output logic                  out_zero,
`endif
    input  logic [DATA_W-1:0]     ula_r
);
    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     ula_a_q, ula_a_d;
    logic [DATA_W-1:0]     ula_b_q, ula_b_d;
    logic [1:0]            func_q, func_d;
    logic [DATA_W-1:0]     res_q, res_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  zero_q, zero_d;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [DATA_W-1:0]     rf_rdata_a, rf_rdata_b;

    ula_regfile u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs1_q),
        .rdata_a (rf_rdata_a),
        .raddr_b (rs2_q),
        .rdata_b (rf_rdata_b)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ula_a_d    = ula_a_q;
        ula_b_d    = ula_b_q;
        func_d     = func_q;
        res_d      = res_q;
        out_data_d = out_data_q;
        zero_d     = zero_q;
        rf_we      = 1'b0;
        rf_waddr   = ld_addr;
        rf_wdata   = ld_data;

        case (state_q)
            IDLE: begin
                // A same-cycle load lands on this edge, so READ sees it.
                rf_we = ld_en;
                if (bus.in_valid) begin
                    op_d    = bus.in_op;
                    rs1_d   = bus.in_rs1;
                    rs2_d   = bus.in_rs2;
                    rd_d    = bus.in_rd;
                    state_d = READ;
                end
            end
            READ: begin
                ula_a_d = rf_rdata_a;
                ula_b_d = rf_rdata_b;
                func_d  = op_q;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = ula_r;
                state_d = WB;
            end
            WB: begin
                rf_we      = 1'b1;
                rf_waddr   = rd_q;
                rf_wdata   = res_q;
                out_data_d = res_q;
                zero_d     = (res_q == '0);
                state_d    = RESP;
            end
            RESP: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ula_a_q    <= '0;
            ula_b_q    <= '0;
            func_q     <= '0;
            res_q      <= '0;
            out_data_q <= '0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ula_a_q    <= ula_a_d;
            ula_b_q    <= ula_b_d;
            func_q     <= func_d;
            res_q      <= res_d;
            out_data_q <= out_data_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == RESP);
    assign bus.out_data  = out_data_q;
    assign ula_a         = ula_a_q;
    assign ula_b         = ula_b_q;
    assign ula_f1        = func_q[1];
    assign ula_f2        = func_q[0];
`ifdef ULA_ZERO_FLAG_EN
    assign out_zero      = zero_q;
`else
    logic unused_zero;
    assign unused_zero   = zero_q;
`endif
endmodule

// File: tb/tb_ula_regfile_ctrl.sv
// Scoreboard bench: controller coupled to a behavioural ALU, directed vectors.
module tb_ula_regfile_ctrl;
    import ula_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_en = 1'b0;
    logic [1:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [7:0] ula_a, ula_b, ula_r;
    logic       ula_f1, ula_f2;
`ifdef ULA_ZERO_FLAG_EN
    logic       out_zero;
`endif

    ula_regfile_ctrl_if bus ();

    ula_regfile_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .bus     (bus.slave),
        .ula_a   (ula_a),
        .ula_b   (ula_b),
        .ula_f1  (ula_f1),
        .ula_f2  (ula_f2),
`ifdef ULA_ZERO_FLAG_EN
        .out_zero(out_zero),
`endif
        .ula_r   (ula_r)
    );

    always #5 clk = ~clk;

    always_comb begin
        case ({ula_f1, ula_f2})
            OP_ADD:  ula_r = ula_a + ula_b;
            OP_SUB:  ula_r = ula_a - ula_b;
            OP_SHL:  ula_r = ula_a << ula_b;
            default: ula_r = ~(ula_a | ula_b);
        endcase
    end

    typedef struct {
        logic [7:0] data;
        logic       zero;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_data", bus.out_data, e.data);
`ifdef ULA_ZERO_FLAG_EN
                chk("out_zero", out_zero, e.zero);
`endif
            end
        end
    end

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [1:0] rd, input logic ld, input logic [1:0] la,
                         input logic [7:0] ldv, input logic [7:0] exp, input int hold);
        int n;
        int guard;
        exp_t e;
        @(posedge clk); #1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_before_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_op = op;
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
        ld_en = ld; ld_addr = la; ld_data = ldv;
        bus.out_ready = (hold == 0);
        e.data = exp; e.zero = (exp == 8'h00);
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; ld_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        chk("latency", n, 4);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            ld_en = (k == 0); ld_addr = 2'd0; ld_data = 8'h55;
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_out_data", bus.out_data, exp);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            ld_en = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_ula_ab", {ula_a, ula_b}, 0);
        chk("rst_ula_f", {ula_f1, ula_f2}, 0);
        for (int i = 0; i < 4; i++) chk("rst_reg", dut.u_rf.regs_q[i], 0);

        load(2'd0, 8'd5); load(2'd1, 8'd3);
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'd0, 8'd8, 0);
        chk("add_r2", dut.u_rf.regs_q[2], 8);

        load(2'd0, 8'd3); load(2'd1, 8'd5);
        issue(OP_SUB, 2'd0, 2'd1, 2'd3, 1'b0, 2'd0, 8'd0, 8'hFE, 0);
        chk("sub_r3", dut.u_rf.regs_q[3], 8'hFE);

        load(2'd0, 8'd1); load(2'd1, 8'd3);
        issue(OP_SHL, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 8'd0, 8'd8, 0);
        chk("shl_ula_a", ula_a, 1);
        chk("shl_ula_b", ula_b, 3);
        chk("shl_func", {ula_f1, ula_f2}, 2'b10);
        issue(OP_ADD, 2'd0, 2'd0, 2'd1, 1'b0, 2'd0, 8'd0, 8'd16, 0);

        // r0=8: hold RESP five cycles, the ld_en offered meanwhile must be dropped
        issue(OP_ADD, 2'd0, 2'd0, 2'd2, 1'b0, 2'd0, 8'd0, 8'd16, 5);
        chk("hold_ld_ignored_r0", dut.u_rf.regs_q[0], 8);

        issue(OP_ADD, 2'd1, 2'd1, 2'd3, 1'b1, 2'd1, 8'd7, 8'd14, 0);
        chk("ld_same_cycle_r1", dut.u_rf.regs_q[1], 7);

        issue(OP_NOR, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'd0, 8'hF0, 0);
        issue(OP_SUB, 2'd1, 2'd1, 2'd1, 1'b0, 2'd0, 8'd0, 8'h00, 0);
        chk("self_overwrite_r1", dut.u_rf.regs_q[1], 0);

        // reset mid-operation: nothing is pushed, so any result is a miscompare
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_op = OP_ADD;
        bus.in_rs1 = 2'd0; bus.in_rs2 = 2'd0; bus.in_rd = 2'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_state_exec", dut.state_q, EXEC);
        rst = 1'b1;
        #1;
        chk("rst_exec_state", dut.state_q, IDLE);
        chk("rst_exec_out_valid", bus.out_valid, 0);
        chk("rst_exec_r3", dut.u_rf.regs_q[3], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("post_rst_r3", dut.u_rf.regs_q[3], 0);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_data", bus.out_data, 0);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
